// File: rtl/window_pos_gen.sv
// window_pos_gen: per-frame scale iteration and raster-order window position stream
module window_pos_gen #(
  parameter int IMG_WIDTH   = 45,
  parameter int IMG_HEIGHT  = 45,
  parameter int W_SCALE     = 4,
  parameter int NUM_SCALES  = 8,
  parameter int WINDOW_SIZE = 24,
  parameter int STEP        = 1,
  localparam int W_X  = $clog2(IMG_WIDTH),
  localparam int WD_X = $clog2(IMG_WIDTH + 1),
  localparam int W_Y  = $clog2(IMG_HEIGHT),
  localparam int WD_Y = $clog2(IMG_HEIGHT + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               busy,
  output logic               done,
  input  logic               scale_info_valid,
  output logic               scale_info_ready,
  input  logic [WD_X-1:0]    scale_info_width,
  input  logic [WD_Y-1:0]    scale_info_height,
  output logic               window_pos_valid,
  input  logic               window_pos_ready,
  output logic               window_pos_eot,
  output logic [W_SCALE-1:0] window_pos_scale,
  output logic [W_X-1:0]     window_pos_x,
  output logic [W_Y-1:0]     window_pos_y
);
  typedef enum logic [1:0] {IDLE, WAIT_SCALE, EMIT, EOT_ONLY} state_t;
  state_t             r_state;
  logic [WD_X-1:0]    r_w;
  logic [WD_Y-1:0]    r_h;
  logic [W_X-1:0]     r_x;
  logic [W_Y-1:0]     r_y;
  logic [W_SCALE-1:0] r_scale;
  logic               r_busy, r_done, r_ready, r_valid;
  logic [WD_X:0]      w_x_nxt, w_x_lim;
  logic [WD_Y:0]      w_y_nxt, w_y_lim;
  logic               w_x_more, w_y_more, w_last_scale, w_big, w_si_hs, w_wp_hs;
  // One extra bit keeps x+STEP and W-WINDOW_SIZE free of wraparound
  assign w_x_nxt      = (WD_X+1)'(r_x) + (WD_X+1)'(STEP);
  assign w_y_nxt      = (WD_Y+1)'(r_y) + (WD_Y+1)'(STEP);
  assign w_x_lim      = {1'b0, r_w} - (WD_X+1)'(WINDOW_SIZE);
  assign w_y_lim      = {1'b0, r_h} - (WD_Y+1)'(WINDOW_SIZE);
  assign w_x_more     = w_x_nxt <= w_x_lim;
  assign w_y_more     = w_y_nxt <= w_y_lim;
  assign w_last_scale = r_scale == W_SCALE'(NUM_SCALES - 1);
  assign w_big        = ({1'b0, scale_info_width} >= (WD_X+1)'(WINDOW_SIZE)) &&
                        ({1'b0, scale_info_height} >= (WD_Y+1)'(WINDOW_SIZE));
  assign w_si_hs      = scale_info_valid & r_ready;
  assign w_wp_hs      = r_valid & window_pos_ready;
  assign busy             = r_busy;
  assign done             = r_done;
  assign scale_info_ready = r_ready;
  assign window_pos_valid = r_valid;
  assign window_pos_scale = r_scale;
  assign window_pos_x     = r_x;
  assign window_pos_y     = r_y;
  assign window_pos_eot   = r_valid & ((r_state == EOT_ONLY) ||
                            (r_state == EMIT && w_last_scale && !w_x_more && !w_y_more));
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_w     <= '0;
      r_h     <= '0;
      r_x     <= '0;
      r_y     <= '0;
      r_scale <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_ready <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: if (start) begin
          r_state <= WAIT_SCALE;
          r_scale <= '0;
          r_busy  <= 1'b1;
          r_ready <= 1'b1;
        end
        WAIT_SCALE: if (w_si_hs) begin
          r_w <= scale_info_width;
          r_h <= scale_info_height;
          r_x <= '0;
          r_y <= '0;
          if (w_big) begin
            r_state <= EMIT;
            r_ready <= 1'b0;
            r_valid <= 1'b1;
          end else if (w_last_scale) begin
            r_state <= EOT_ONLY;
            r_ready <= 1'b0;
            r_valid <= 1'b1;
          end else begin
            r_scale <= r_scale + W_SCALE'(1);
          end
        end
        EMIT: if (w_wp_hs) begin
          if (w_x_more) begin
            r_x <= w_x_nxt[W_X-1:0];
          end else begin
            r_x <= '0;
            if (w_y_more) begin
              r_y <= w_y_nxt[W_Y-1:0];
            end else if (!w_last_scale) begin
              r_state <= WAIT_SCALE;
              r_scale <= r_scale + W_SCALE'(1);
              r_valid <= 1'b0;
              r_ready <= 1'b1;
            end else begin
              r_state <= IDLE;
              r_valid <= 1'b0;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end
          end
        end
        EOT_ONLY: if (w_wp_hs) begin
          r_state <= IDLE;
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_window_pos_gen.sv
// tb_window_pos_gen: randomized checks of window_pos_gen against a loop-based position model
module tb_window_pos_gen;
  localparam int WS = 24;
  localparam int NI = 3;
  localparam int ST[NI] = '{1, 4, 1};
  localparam int NS[NI] = '{2, 1, 3};
  typedef struct {int s; int x; int y; bit e;} beat_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start[NI], busy[NI], done[NI], siv[NI], sir[NI], pv[NI], pr[NI], peot[NI];
  logic [5:0] sw[NI], sh[NI], px[NI], py[NI];
  logic [3:0] psc[NI];
  int checks = 0, failures = 0;
  int ws[4], hs[4];
  beat_t got[$];
  int bcyc[$], hcyc[$];
  always #5 clk = ~clk;
  for (genvar g = 0; g < NI; g++) begin : g_dut
    window_pos_gen #(.IMG_WIDTH(45), .IMG_HEIGHT(45), .W_SCALE(4), .NUM_SCALES(NS[g]),
                     .WINDOW_SIZE(WS), .STEP(ST[g])) u_dut (
      .clk(clk), .rst(rst), .start(start[g]), .busy(busy[g]), .done(done[g]),
      .scale_info_valid(siv[g]), .scale_info_ready(sir[g]),
      .scale_info_width(sw[g]), .scale_info_height(sh[g]),
      .window_pos_valid(pv[g]), .window_pos_ready(pr[g]), .window_pos_eot(peot[g]),
      .window_pos_scale(psc[g]), .window_pos_x(px[g]), .window_pos_y(py[g]));
  end
  task automatic build_exp(input int d, output beat_t q[$]);
    beat_t b;
    q = {};
    for (int s = 0; s < NS[d]; s++)
      if (ws[s] >= WS && hs[s] >= WS)
        for (int y = 0; y <= hs[s] - WS; y += ST[d])
          for (int x = 0; x <= ws[s] - WS; x += ST[d])
            q.push_back('{s, x, y, 1'b0});
    if (ws[NS[d]-1] >= WS && hs[NS[d]-1] >= WS) begin
      b = q.pop_back();
      b.e = 1'b1;
      q.push_back(b);
    end else q.push_back('{NS[d] - 1, 0, 0, 1'b1});
  endtask
  task automatic run_frame(input int d, input bit rr, input bit rs, input bit restart);
    beat_t exp[$];
    logic [17:0] snap;
    bit stall = 0, fin = 0;
    int s = 0, cyc = 0;
    build_exp(d, exp);
    got = {}; bcyc = {}; hcyc = {};
    @(negedge clk); start[d] = 1'b1;
    @(negedge clk); start[d] = 1'b0;
    checks++;
    if (busy[d] !== 1'b1) begin failures++; $display("FAIL busy_after_start d=%0d got=%b exp=1", d, busy[d]); end
    while (!fin && cyc < 10000) begin
      start[d] = restart && got.size() == 3;
      siv[d] = (s < NS[d]) && (rs ? $urandom_range(0, 2) != 0 : 1'b1);
      sw[d] = siv[d] ? 6'(ws[s]) : 6'd0;
      sh[d] = siv[d] ? 6'(hs[s]) : 6'd0;
      if (siv[d] && sir[d]) begin hcyc.push_back(cyc); s++; end
      pr[d] = rr ? 1'($urandom_range(0, 1)) : 1'b1;
      if (stall) begin
        checks++;
        if ({pv[d], peot[d], psc[d], px[d], py[d]} !== snap) begin
          failures++; $display("FAIL stall_stable d=%0d cyc=%0d got=%h exp=%h", d, cyc, {pv[d], peot[d], psc[d], px[d], py[d]}, snap);
        end
      end
      stall = pv[d] && !pr[d];
      snap = {pv[d], peot[d], psc[d], px[d], py[d]};
      if (pv[d] && pr[d]) begin
        got.push_back('{int'(psc[d]), int'(px[d]), int'(py[d]), peot[d]});
        bcyc.push_back(cyc);
        fin = peot[d];
      end
      @(negedge clk); cyc++;
    end
    start[d] = 1'b0; siv[d] = 1'b0; pr[d] = 1'b0;
    checks++;
    if (!fin) begin failures++; $display("FAIL frame_timeout d=%0d beats=%0d exp=%0d", d, got.size(), exp.size()); end
    checks++;
    if (done[d] !== 1'b1 || busy[d] !== 1'b0) begin
      failures++; $display("FAIL done_pulse d=%0d done=%b busy=%b exp done=1 busy=0", d, done[d], busy[d]);
    end
    @(negedge clk);
    checks++;
    if (done[d] !== 1'b0) begin failures++; $display("FAIL done_width d=%0d got=%b exp=0", d, done[d]); end
    checks++;
    if (got.size() != exp.size()) begin failures++; $display("FAIL beat_count d=%0d got=%0d exp=%0d", d, got.size(), exp.size()); end
    for (int i = 0; i < got.size() && i < exp.size(); i++) begin
      checks++;
      if (got[i].s != exp[i].s || got[i].x != exp[i].x || got[i].y != exp[i].y || got[i].e != exp[i].e) begin
        failures++;
        $display("FAIL beat[%0d] d=%0d got s=%0d x=%0d y=%0d e=%0d exp s=%0d x=%0d y=%0d e=%0d",
                 i, d, got[i].s, got[i].x, got[i].y, got[i].e, exp[i].s, exp[i].x, exp[i].y, exp[i].e);
      end
    end
  endtask
  task automatic test_reset();
    for (int d = 0; d < NI; d++) begin
      checks++;
      if ({busy[d], done[d], sir[d], pv[d], peot[d], psc[d], px[d], py[d]} !== '0) begin
        failures++; $display("FAIL reset_state d=%0d got=%h exp=0", d, {busy[d], done[d], sir[d], pv[d], peot[d], psc[d], px[d], py[d]});
      end
    end
  endtask
  task automatic test_basic();
    ws = '{26, 24, 0, 0}; hs = '{26, 24, 0, 0};
    run_frame(0, 1'b0, 1'b0, 1'b0);
    if (got.size() == 10 && hcyc.size() == 2) begin
      checks++;
      if (bcyc[0] != hcyc[0] + 1) begin failures++; $display("FAIL first_latency got=%0d exp=%0d", bcyc[0] - hcyc[0], 1); end
      checks++;
      if (bcyc[8] - bcyc[0] != 8) begin failures++; $display("FAIL throughput got=%0d exp=8", bcyc[8] - bcyc[0]); end
      checks++;
      if (bcyc[9] - bcyc[8] != 2) begin failures++; $display("FAIL scale_bubble got=%0d exp=2", bcyc[9] - bcyc[8]); end
    end
  endtask
  task automatic test_stall();
    ws = '{26, 24, 0, 0}; hs = '{26, 24, 0, 0};
    run_frame(0, 1'b1, 1'b1, 1'b0);
  endtask
  task automatic test_step4();
    ws = '{45, 0, 0, 0}; hs = '{30, 0, 0, 0};
    run_frame(1, 1'b1, 1'b0, 1'b0);
  endtask
  task automatic test_degenerate();
    ws = '{30, 20, 10, 0}; hs = '{25, 40, 10, 0};
    run_frame(2, 1'b1, 1'b1, 1'b0);
  endtask
  task automatic test_restart();
    ws = '{27, 25, 0, 0}; hs = '{25, 26, 0, 0};
    run_frame(0, 1'b0, 1'b0, 1'b1);
  endtask
  task automatic test_reset_mid();
    int n = 0;
    @(negedge clk); start[2] = 1'b1;
    @(negedge clk); start[2] = 1'b0; siv[2] = 1'b1; sw[2] = 6'd30; sh[2] = 6'd30; pr[2] = 1'b0;
    while (!pv[2] && n < 20) begin @(negedge clk); n++; end
    siv[2] = 1'b0;
    checks++;
    if (pv[2] !== 1'b1) begin failures++; $display("FAIL reach_emit got=%b exp=1", pv[2]); end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({pv[2], busy[2], done[2], peot[2]} !== 4'b0) begin
      failures++; $display("FAIL async_reset got=%b exp=0000", {pv[2], busy[2], done[2], peot[2]});
    end
    @(negedge clk); rst = 1'b0;
    ws = '{$urandom_range(24, 45), $urandom_range(10, 45), $urandom_range(24, 45), 0};
    hs = '{$urandom_range(24, 45), $urandom_range(10, 45), $urandom_range(10, 45), 0};
    run_frame(2, 1'b1, 1'b1, 1'b0);
  endtask
  task automatic test_random();
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < 4; i++) begin ws[i] = $urandom_range(10, 45); hs[i] = $urandom_range(10, 45); end
      run_frame(k % NI, 1'($urandom_range(0, 1)), 1'b1, 1'b0);
    end
  endtask
  initial begin
    for (int d = 0; d < NI; d++) begin
      start[d] = 1'b0; siv[d] = 1'b0; pr[d] = 1'b0; sw[d] = '0; sh[d] = '0;
    end
    repeat (3) @(negedge clk);
    test_reset();
    rst = 1'b0;
    test_basic();
    test_stall();
    test_step4();
    test_degenerate();
    test_restart();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/window_pos_gen.md
Name: window_pos_gen

Overview:
- Source of the window-position stream consumed by the classifier-result/position join stage.
- Per frame, iterates over NUM_SCALES image scales and requests each scaled image's dimensions from the scaler over a valid/ready handshake.
- Emits every legal top-left window position in raster order (x inner, y outer) as a valid/ready stream.
- Flags the final beat of the frame with eot.

Parameters:
- IMG_WIDTH, 45: maximum scaled image width; W_X = $clog2(IMG_WIDTH), WD_X = $clog2(IMG_WIDTH+1).
- IMG_HEIGHT, 45: maximum scaled image height; W_Y = $clog2(IMG_HEIGHT), WD_Y = $clog2(IMG_HEIGHT+1).
- W_SCALE, 4: width of the scale index.
- NUM_SCALES, 8: scales per frame, 1 ≤ NUM_SCALES ≤ 2**W_SCALE.
- WINDOW_SIZE, 24: square detection window edge in pixels.
- STEP, 1: window stride in pixels, ≥ 1.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- start  in  1  single-cycle frame start request
- busy  out  1  frame in progress
- done  out  1  one-cycle pulse after the eot beat handshakes
- scale_info_valid  in  1  scaler presents dimensions
- scale_info_ready  out  1  generator accepts dimensions
- scale_info_width  in  WD_X  scaled image width
- scale_info_height  in  WD_Y  scaled image height
- window_pos_valid  out  1  position beat valid
- window_pos_ready  in  1  downstream accepts beat
- window_pos_eot  out  1  last beat of frame
- window_pos_scale  out  W_SCALE  current scale index
- window_pos_x  out  W_X  window top-left x
- window_pos_y  out  W_Y  window top-left y

Behaviour:
- Reset (async, active-high): state IDLE; all outputs 0, including busy, done, scale_info_ready, window_pos_valid and eot; x, y, scale counters 0.
- FSM states:
  - IDLE: start=1 -> WAIT_SCALE; scale counter := 0; busy=1 from next cycle.
  - WAIT_SCALE: scale_info_ready=1. On scale_info handshake, latch width W and height H, x := 0, y := 0.
    - If W ≥ WINDOW_SIZE and H ≥ WINDOW_SIZE -> EMIT.
    - Else (degenerate scale): if not the last scale, scale++ and stay in WAIT_SCALE; if the last scale -> EOT_ONLY.
  - EMIT: window_pos_valid=1, registered outputs. On handshake:
    - If x+STEP ≤ W-WINDOW_SIZE: x += STEP.
    - Else x := 0, and if y+STEP ≤ H-WINDOW_SIZE: y += STEP.
    - Else the scale is complete: if not the last scale, scale++ -> WAIT_SCALE; if the last scale -> IDLE.
  - EOT_ONLY: single beat x=0, y=0, scale=NUM_SCALES-1, eot=1. On handshake -> IDLE.
- Arithmetic: all comparisons at WD_X+1 / WD_Y+1 bits so there is no underflow or overflow. A non-multiple remainder is skipped: the last x is the largest k*STEP ≤ W-WINDOW_SIZE.
- eot=1 exactly on the final beat of the frame: the last position of the last scale, or the EOT_ONLY beat.
- Handshake:
  - x, y, scale, eot and valid are held stable while valid & !ready.
  - Throughput is 1 beat/cycle within a scale.
  - Minimum 1 bubble cycle between scales (the WAIT_SCALE handshake).
  - First beat appears 1 cycle after the scale_info handshake.
- done pulses for one cycle in the cycle after the eot handshake; busy drops in that same cycle.
- start while busy is ignored and does not queue. scale_info_valid outside WAIT_SCALE is ignored (ready=0).
- Reset mid-frame aborts immediately: no eot and no done are emitted; the next start begins at scale 0.

Test Plan:
- WINDOW_SIZE=24, STEP=1, NUM_SCALES=2; scale 0 = 26x26, scale 1 = 24x24, ready always 1 -> 10 beats. Scale 0 in order (0,0),(1,0),(2,0),(0,1)…(2,2). Scale 1: (0,0) with eot=1, scale=1. One bubble between scales; done one cycle after the last handshake.
- Same stimulus with window_pos_ready toggling pseudo-randomly -> identical beat sequence, no drops or duplicates, outputs stable while stalled.
- STEP=4, scale 0 = 45x30, NUM_SCALES=1 -> x ∈ {0,4,8,12,16,20}, y ∈ {0,4}. 12 beats; eot on (20,4).
- NUM_SCALES=3; scale 1 = 20x40 (degenerate), scale 2 = 10x10 (degenerate) -> scale 0 beats, then one EOT_ONLY beat (0,0), scale=2, eot=1.
- start asserted again mid-frame -> ignored, beat count unchanged. Reset asserted mid-EMIT -> valid, busy and done 0 asynchronously. A subsequent start restarts at scale 0, (0,0).
